// File: rtl/input_fifo_buffer_pkg.sv
// Shared router definitions: packet bus width, router id and input-port indices.
package input_fifo_buffer_pkg;

  localparam int unsigned packetwidth = 55;
  localparam int unsigned routerNo    = 0;

  typedef enum logic [2:0] {
    port_east  = 3'd0,
    port_north = 3'd1,
    port_west  = 3'd2,
    port_south = 3'd3,
    port_local = 3'd4
  } port_e;

endpackage

// File: rtl/input_fifo_buffer_fifo_mem.sv
// Simple dual-port packet array: synchronous write, asynchronous read at the read pointer.
module fifo_mem
  import input_fifo_buffer_pkg::*;
#(
  parameter int unsigned width = packetwidth,
  parameter int unsigned depth = 4,
  parameter int unsigned addrw = $clog2(depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [addrw-1:0] waddr,
  input  logic [width-1:0] wdata,
  input  logic [addrw-1:0] raddr,
  output logic [width-1:0] rdata_c
);

  logic [width-1:0] mem [depth];

  // Storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/input_fifo_buffer.sv
// Per-port input packet FIFO: link-side write strobe in, req/gnt/empty responder toward the
// port controller, one pop per accepted request with a one-cycle grant pulse.
module input_fifo_buffer #(
  parameter int unsigned packetwidth = input_fifo_buffer_pkg::packetwidth,
  parameter int unsigned depth       = 4,
  parameter int unsigned addrw       = $clog2(depth)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic [packetwidth-1:0] PacketIn,
  output logic                   full,
  input  logic                   req,
  output logic                   gnt,
  output logic                   empty,
  output logic [packetwidth-1:0] PacketOut,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned cntw = addrw + 1;

  logic [addrw-1:0]       wptr, wptr_nxt;
  logic [addrw-1:0]       rptr, rptr_nxt;
  logic [cntw-1:0]        count, count_nxt;
  logic                   push_c, pop_c;
  logic [packetwidth-1:0] head_c;

  fifo_mem #(
    .width (packetwidth),
    .depth (depth),
    .addrw (addrw)
  ) u_mem (
    .clk     (clk),
    .we      (push_c),
    .waddr   (wptr),
    .wdata   (PacketIn),
    .raddr   (rptr),
    .rdata_c (head_c)
  );

  // A request arriving while a grant is showing is ignored, giving one grant per request pulse.
  always_comb begin
    push_c    = wr && !full;
    pop_c     = req && (count != '0) && !gnt;
    wptr_nxt  = wptr;
    rptr_nxt  = rptr;
    count_nxt = count;
    if (push_c) wptr_nxt = wptr + addrw'(1);
    if (pop_c)  rptr_nxt = rptr + addrw'(1);
    case ({push_c, pop_c})
      2'b10:   count_nxt = count + cntw'(1);
      2'b01:   count_nxt = count - cntw'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      gnt       <= 1'b0;
      PacketOut <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr  <= wptr_nxt;
      rptr  <= rptr_nxt;
      count <= count_nxt;
      gnt   <= pop_c;
      if (pop_c) PacketOut <= head_c;
      full  <= (count_nxt == cntw'(depth));
      empty <= (count_nxt == '0);
      if (wr && full)         overflow  <= 1'b1;
      if (req && count == '0) underflow <= 1'b1;
    end
  end

endmodule

// File: doc/input_fifo_buffer.md
# input_fifo_buffer

Per-port packet FIFO in each mesh router, between the incoming link and the input port controller. Accepts packets from the link side with a write strobe and serves the port controller over the `req`/`gnt`/`empty` handshake: it pops one packet per accepted request, presents it on `PacketOut`, and pulses `gnt`. It is the responder end of the controller's request protocol.

## Interface
- `packetwidth`, 55: packet bus width in bits.
- `depth`, 4: number of packet entries; must be a power of two, 2 or more.
- `addrw`, `$clog2(depth)`: pointer width (derived).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr`  in  1  link-side write strobe, one packet per cycle while high.
- `PacketIn`  in  packetwidth  link-side packet, sampled when `wr`=1.
- `full`  out  1  registered; 1 when count == depth.
- `req`  in  1  read request from the port controller, level-sampled.
- `gnt`  out  1  registered one-cycle grant pulse.
- `empty`  out  1  registered; 1 when count == 0.
- `PacketOut`  out  packetwidth  registered head packet of the last grant, held until the next grant.
- `overflow`  out  1  sticky; a write was attempted while full.
- `underflow`  out  1  sticky; `req` was sampled while count == 0.

## Operation
- Storage: `depth`-entry array with `addrw`-bit write and read pointers that wrap modulo `depth`, and an `addrw+1`-bit count.
- Push: `wr`=1 and not full → store at wptr, then wptr+1. `wr`=1 while full → data dropped, pointers and count unchanged, `overflow` set.
- Pop: `req`=1, count>0 and `gnt`=0 → `PacketOut` ← mem[rptr], rptr+1, `gnt`=1 next cycle.
- `req` while `gnt`=1 → ignored. This enforces one grant per request pulse.
- `req` while count == 0 → ignored, no `gnt`, `underflow` set. This case is a protocol violation.
- Push and pop in the same cycle: count unchanged and both pointers advance. A push into the slot being read does not affect the popped data, which is the old head.
- A push while full with a simultaneous pop is still rejected, because `full` is evaluated before the edge.
- `full` and `empty` are recomputed from the next-state count, so they are valid in the cycle after any push or pop.
- Flags `overflow` and `underflow` clear only on reset.

## Timing
- Reset (async, `reset`=0): pointers=0, count=0, `gnt`=0, `PacketOut`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0. Memory contents are not reset. Asserting reset mid-transfer discards all entries and any pending grant.
- Write to visible: a packet written at edge E makes `empty`=0 after E.
- Handshake latency: `req` sampled high at edge E → `gnt`=1 and new `PacketOut` after E → `gnt`=0 after E+1. `PacketOut` stays stable at least until the next grant, so the controller can capture it at E+2.
- Controller round trip: the controller sees `empty`=0 and raises `req`, with the grant following as above. The next `empty` it samples already reflects the pop.
- Throughput: at most one pop per two cycles, one push per cycle.

## Structure
- Shared package/header: `packetwidth`, `routerNo`, port-index constants (East 0, North 1, West 2, South 3, Local 4). This block uses only `packetwidth`.
- One sub-module is natural: `fifo_mem`, a simple dual-port array with a synchronous write and an asynchronous read at rptr. Pointer, count, flag and grant logic stay in the top.

## Test plan
- Reset, then write A=55'h1 and B=55'h2 → `empty` goes to 0 after the first write. Pulse `req` → `gnt` after 1 cycle with `PacketOut`=1. Next `req` → `PacketOut`=2, then `empty`=1.
- Write 4 packets (depth 4) → `full`=1. A 5th write → dropped, `overflow`=1. Pop 4 times → values come out in write order, then `empty`=1.
- Hold `req` high for 3 cycles with 2 entries queued → exactly one `gnt` per two cycles. The `gnt`-high cycle issues no second pop.
- Full FIFO, same-cycle `wr` and pop → write rejected, `overflow`=1, count=3. With count=2, same-cycle push and pop → count stays 2 and the old head is returned.
- Drive `req` with `empty`=1 → no `gnt`, `underflow`=1, `PacketOut` unchanged.
- Drop `reset` low one cycle after `req` with 3 entries queued → all outputs at reset values immediately. After release, `empty`=1 and no spurious `gnt`.
- Run 10 packets through with wraparound alongside the port controller model → the controller captures each packet intact.
